dco_cal_ctrl: RTL

DCO_CAL_CTRL -- requirements
Module: dco_cal_ctrl

---
 rtl/dco_cal_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dco_cal_ctrl.sv
// Successive-approximation DCO calibration controller: eight binary-search
// steps on an 8-bit tuning code, then one verify window against a tolerance.
module dco_cal_ctrl #(
  parameter int CNT_W  = 12,
  parameter int WIN    = 1000,
  parameter int SETTLE = 64,
  parameter int TOL    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target,
  input  logic             fb_pulse,
  output logic [7:0]       dco_code,
  output logic             dco_upd,
  output logic             div_en1,
  output logic             div_en2,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_err,
  output logic [2:0]       dbg_state
);

  localparam int TMR_W = $clog2((WIN > SETTLE ? WIN : SETTLE) + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DECIDE, ST_VERIFY_S, ST_VERIFY_M, ST_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       code_d, trial;
  logic [CNT_W:0]   diff;
  logic             upd_d, done_d, err_d, busy_d, en1_d, en2_d;

  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q + TMR_W'(1);
    code_d    = dco_code;
    upd_d     = 1'b0;
    done_d    = cal_done;
    err_d     = cal_err;
    trial     = dco_code;
    diff      = '0;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (start && !abort) begin
          tgt_d     = target;
          bit_idx_d = 3'd7;
          code_d    = 8'h80;
          upd_d     = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE, ST_VERIFY_S: begin
        if (tmr_q == TMR_W'(SETTLE - 1)) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = (state_q == ST_SETTLE) ? ST_MEASURE : ST_VERIFY_M;
        end
      end
      ST_MEASURE, ST_VERIFY_M: begin
        // Count saturates so an over-fast DCO still reads as "too high".
        if (fb_pulse && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (tmr_q == TMR_W'(WIN - 1)) begin
          tmr_d   = '0;
          state_d = (state_q == ST_MEASURE) ? ST_DECIDE : ST_CHECK;
        end
      end
      ST_DECIDE: begin
        tmr_d = '0;
        if (cnt_q > tgt_q) trial[bit_idx_q] = 1'b0;
        if (bit_idx_q != 3'd0) begin
          trial[bit_idx_q - 3'd1] = 1'b1;
          bit_idx_d = bit_idx_q - 3'd1;
          upd_d     = 1'b1;
          state_d   = ST_SETTLE;
        end else begin
          upd_d   = (trial != dco_code);
          state_d = ST_VERIFY_S;
        end
        code_d = trial;
      end
      ST_CHECK: begin
        tmr_d = '0;
        diff  = (cnt_q >= tgt_q) ? ({1'b0, cnt_q} - {1'b0, tgt_q})
                                 : ({1'b0, tgt_q} - {1'b0, cnt_q});
        if (diff <= (CNT_W + 1)'(TOL)) done_d = 1'b1;
        else                          err_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort freezes the code where it is; only the flags and state move.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      code_d  = dco_code;
      upd_d   = 1'b0;
      tmr_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
    en1_d  = busy_d && (state_d != ST_CHECK);
    en2_d  = (state_d == ST_MEASURE) || (state_d == ST_VERIFY_M);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 3'd7;
      tgt_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      dco_code  <= 8'h80;
      dco_upd   <= 1'b0;
      div_en1   <= 1'b0;
      div_en2   <= 1'b0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      dco_code  <= code_d;
      dco_upd   <= upd_d;
      div_en1   <= en1_d;
      div_en2   <= en2_d;
      cal_busy  <= busy_d;
      cal_done  <= done_d;
      cal_err   <= err_d;
    end
  end

endmodule
